param_vertical_timing_generator: RTL and testbench
==================================================

# param_vertical_timing_generator

Parametrised vertical timing generator for the VGA controller. It counts lines from the horizontal generator's `new_line` pulse and produces the line counter, a scaled-down row index for VRAM addressing, VSYNC, vertical-active and frame-start strobes. Porch/sync/active lengths, scale factor, counter widths and sync polarity are all parameters. It is the successor to the fixed 640x480@60 vertical counter.

## Interface
Parameters:
- `V_ACTIVE`, 480, active video lines
- `V_FP`, 10, front-porch lines
- `V_SYNC`, 2, sync-pulse lines
- `V_BP`, 33, back-porch lines
- `SCALE`, 5, display lines per VRAM row (>=1)
- `CNT_W`, 10, width of `ver_cnt`; must hold V_TOTAL-1
- `SCL_W`, 7, width of `scl_ver_cnt`; must hold ceil(V_ACTIVE/SCALE)-1
- `SYNC_POL`, 0, VSYNC level during sync (0 = active-low)

Ports:
- `clk` input 1: single clock; all logic on its rising edge
- `reset` input 1: synchronous, active-high
- `new_line` input 1: one-cycle pulse from horizontal generator, end of line
- `ver_cnt` output CNT_W: current line, 0..V_TOTAL-1
- `scl_ver_cnt` output SCL_W: scaled active row index
- `v_phase` output 2: 0=SYNC, 1=BACK, 2=ACTIVE, 3=FRONT
- `VSYNC` output 1: vertical sync
- `v_active` output 1: high during active lines
- `frame_start` output 1: one-cycle strobe at start of line 0
- `frame_cnt` output 8: frame counter (see Configuration)

## Operation
- V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (default 525). Line order: SYNC [0, V_SYNC), BACK [V_SYNC, V_SYNC+V_BP), ACTIVE [A0 = V_SYNC+V_BP, A0+V_ACTIVE), FRONT [to V_TOTAL-1].
- FSM `v_phase`: SYNC->BACK->ACTIVE->FRONT->SYNC. Transition taken on a `new_line` when `ver_cnt` is the last line of the current phase. Zero-length V_BP or V_FP is not supported (min 1).
- `ver_cnt`: +1 on each `new_line`; at V_TOTAL-1 wraps to 0. Holds otherwise.
- Scale logic: internal `scale_cnt` (ceil log2 SCALE bits). Outside ACTIVE, `scale_cnt`=0 and `scl_ver_cnt`=0. On entering ACTIVE both are 0. Each `new_line` inside ACTIVE (not the last active line): if `scale_cnt`==SCALE-1, set it to 0 and increment `scl_ver_cnt`; else increment `scale_cnt`. Leaving ACTIVE clears both. Default: rows 0..95, 5 lines each. A non-divisible V_ACTIVE gives a short final row.
- `VSYNC` = SYNC_POL when `v_phase`==SYNC, else ~SYNC_POL. `v_active` = (`v_phase`==ACTIVE).
- `frame_start` pulses on the cycle after the wrap V_TOTAL-1->0. It does not pulse on reset release.
- `new_line` high on k consecutive cycles counts as k lines. No filtering.

## Timing
- All outputs are registered and mutually consistent in every cycle. `VSYNC`, `v_active`, `v_phase` and `scl_ver_cnt` always describe the current `ver_cnt` (no one-line lag).
- Latency: `new_line` sampled at edge N; updated outputs are visible after edge N, i.e. 1 cycle.
- Reset values: `ver_cnt`=0, `v_phase`=SYNC, `VSYNC`=SYNC_POL, `v_active`=0, `scl_ver_cnt`=0, `scale_cnt`=0, `frame_start`=0, `frame_cnt`=0.
- `reset` takes priority over `new_line` in the same cycle.
- Reset mid-frame returns to line 0 SYNC on the next edge, with no `frame_start`.

## Configuration
- `VTG_FRAME_CNT_EN` defined: `frame_cnt` increments (mod 256) on every wrap to line 0, in the same cycle as `frame_start`. Used for blink/animation.
- Undefined: the port exists but is tied to 8'd0, and no counter logic is built.

## Test plan
- Reset held 3 cycles with `new_line`=1 -> all outputs at the reset values above; `ver_cnt` stays 0.
- Defaults, `new_line` every 4 clocks for 2 frames -> `VSYNC`=0 on lines 0-1 only; `v_active`=1 on lines 35..514; `scl_ver_cnt` increments on lines 40,45,…,510, reaching 95; 524->0 wrap with `frame_start` 1 cycle.
- Override V_SYNC=1, V_BP=1, V_ACTIVE=6, V_FP=1, SCALE=4, SYNC_POL=1 -> period 9 lines; VSYNC=1 on line 0 only; scl 0 for lines 2-5 and 1 for lines 6-7 (short row); back to 0 on line 8.
- Reset asserted at line 300 coincident with `new_line` -> next cycle `ver_cnt`=0, SYNC, `scl_ver_cnt`=0, no `frame_start`.
- Back-to-back `new_line` for 3 cycles at line 33 -> `ver_cnt` 34, 35, 36; `v_active` rises with 35; scale_cnt 0 then 1.
- With `VTG_FRAME_CNT_EN`, run 257 frames (small params) -> `frame_cnt` reads 255 then 0 then 1. Without the macro it stays 0 throughout.

Source files
------------

// File: rtl/param_vertical_timing_generator.sv
// ---------------------------------------------------------------------------
// param_vertical_timing_generator
//
// Vertical timing generator for the VGA controller. Counts lines on the
// horizontal generator's new_line pulse and derives the line counter, a
// scaled row index for VRAM addressing, VSYNC, vertical-active and a
// frame-start strobe. Porch/sync/active lengths, scale factor, counter
// widths and sync polarity are parameters.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   new_line     in   one-cycle end-of-line pulse (k cycles high = k lines)
//   ver_cnt      out  current line, 0..V_TOTAL-1
//   scl_ver_cnt  out  active row index (SCALE display lines per row)
//   v_phase      out  0=SYNC 1=BACK 2=ACTIVE 3=FRONT
//   VSYNC        out  SYNC_POL during sync lines, inverted otherwise
//   v_active     out  high on active lines
//   frame_start  out  one-cycle strobe after the wrap to line 0
//   frame_cnt    out  frame counter (mod 256)
//
// Optional feature macro: VTG_FRAME_CNT_EN
//   defined   -> frame_cnt counts wraps to line 0
//   undefined -> frame_cnt is tied to 8'd0, no counter is built
//
// All outputs are registered from the next-state values, so phase, sync,
// active and row index always describe the line shown on ver_cnt.
// ---------------------------------------------------------------------------
module param_vertical_timing_generator #(
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   SCALE    = 5,
  parameter int   CNT_W    = 10,
  parameter int   SCL_W    = 7,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_line,
  output logic [CNT_W-1:0] ver_cnt,
  output logic [SCL_W-1:0] scl_ver_cnt,
  output logic [1:0]       v_phase,
  output logic             VSYNC,
  output logic             v_active,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  // SCALE == 1 would give a zero-width counter; keep at least one bit.
  localparam int SC_W    = (SCALE > 1) ? $clog2(SCALE) : 1;

  // Last line of each phase; a phase change happens on new_line at these.
  localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(V_SYNC - 1);
  localparam logic [CNT_W-1:0] BACK_END  = CNT_W'(V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(V_TOTAL - 1);
  localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(SCALE - 1);

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_BACK   = 2'd1,
    PH_ACTIVE = 2'd2,
    PH_FRONT  = 2'd3
  } phase_t;

  phase_t             ph_r;
  phase_t             ph_nxt_s;
  logic [CNT_W-1:0]   ver_cnt_r;
  logic [CNT_W-1:0]   ver_nxt_s;
  logic [SC_W-1:0]    scale_cnt_r;
  logic [SC_W-1:0]    scale_nxt_s;
  logic [SCL_W-1:0]   scl_r;
  logic [SCL_W-1:0]   scl_nxt_s;
  logic               vsync_r;
  logic               active_r;
  logic               fs_r;
  logic               wrap_s;

  // Next line, phase and scale state for the coming edge.
  always_comb begin
    ver_nxt_s   = ver_cnt_r;
    ph_nxt_s    = ph_r;
    scale_nxt_s = scale_cnt_r;
    scl_nxt_s   = scl_r;
    wrap_s      = 1'b0;
    if (new_line) begin
      if (ver_cnt_r == LAST_LINE) begin
        ver_nxt_s = {CNT_W{1'b0}};
        wrap_s    = 1'b1;
      end else begin
        ver_nxt_s = ver_cnt_r + CNT_W'(1);
        wrap_s    = 1'b0;
      end
      case (ph_r)
        PH_SYNC: begin
          if (ver_cnt_r == SYNC_END) begin
            ph_nxt_s = PH_BACK;
          end else begin
            ph_nxt_s = PH_SYNC;
          end
        end
        PH_BACK: begin
          // Entering active: the row index starts clean at row 0.
          if (ver_cnt_r == BACK_END) begin
            ph_nxt_s    = PH_ACTIVE;
            scale_nxt_s = {SC_W{1'b0}};
            scl_nxt_s   = {SCL_W{1'b0}};
          end else begin
            ph_nxt_s = PH_BACK;
          end
        end
        PH_ACTIVE: begin
          if (ver_cnt_r == ACT_END) begin
            ph_nxt_s    = PH_FRONT;
            scale_nxt_s = {SC_W{1'b0}};
            scl_nxt_s   = {SCL_W{1'b0}};
          end else if (scale_cnt_r == SC_LAST) begin
            // Row complete: advance to the next VRAM row.
            ph_nxt_s    = PH_ACTIVE;
            scale_nxt_s = {SC_W{1'b0}};
            scl_nxt_s   = scl_r + SCL_W'(1);
          end else begin
            ph_nxt_s    = PH_ACTIVE;
            scale_nxt_s = scale_cnt_r + SC_W'(1);
          end
        end
        PH_FRONT: begin
          if (ver_cnt_r == LAST_LINE) begin
            ph_nxt_s = PH_SYNC;
          end else begin
            ph_nxt_s = PH_FRONT;
          end
        end
        default: begin
          ph_nxt_s    = PH_SYNC;
          scale_nxt_s = {SC_W{1'b0}};
          scl_nxt_s   = {SCL_W{1'b0}};
        end
      endcase
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Register line state and decode flags from the next phase (no lag).
  always_ff @(posedge clk) begin
    if (reset) begin
      ver_cnt_r   <= {CNT_W{1'b0}};
      ph_r        <= PH_SYNC;
      scale_cnt_r <= {SC_W{1'b0}};
      scl_r       <= {SCL_W{1'b0}};
      vsync_r     <= SYNC_POL;
      active_r    <= 1'b0;
      fs_r        <= 1'b0;
    end else begin
      ver_cnt_r   <= ver_nxt_s;
      ph_r        <= ph_nxt_s;
      scale_cnt_r <= scale_nxt_s;
      scl_r       <= scl_nxt_s;
      vsync_r     <= (ph_nxt_s == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      active_r    <= (ph_nxt_s == PH_ACTIVE);
      fs_r        <= wrap_s;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  logic [7:0] frame_cnt_r;

  // Frame counter advances with each wrap, alongside frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_r <= 8'd0;
    end else if (wrap_s) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`else
  assign frame_cnt = 8'd0;
`endif

  assign ver_cnt     = ver_cnt_r;
  assign scl_ver_cnt = scl_r;
  assign v_phase     = ph_r;
  assign VSYNC       = vsync_r;
  assign v_active    = active_r;
  assign frame_start = fs_r;

endmodule

// File: tb/tb_param_vertical_timing_generator.sv
// ---------------------------------------------------------------------------
// Testbench for param_vertical_timing_generator.
// Instance u_a uses default parameters (525-line frame, new_line every
// 4 clocks); instance u_b uses a 9-line frame with SCALE=4, SYNC_POL=1 and
// new_line held high continuously.
// ---------------------------------------------------------------------------
module tb_param_vertical_timing_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, nl_a, rst_b, nl_b;
  logic [9:0] a_ver;
  logic [6:0] a_scl;
  logic [1:0] a_ph;
  logic       a_vs, a_act, a_fs;
  logic [7:0] a_fc;
  logic [3:0] b_ver;
  logic [1:0] b_scl;
  logic [1:0] b_ph;
  logic       b_vs, b_act, b_fs;
  logic [7:0] b_fc;

  param_vertical_timing_generator u_a (
    .clk(clk), .reset(rst_a), .new_line(nl_a),
    .ver_cnt(a_ver), .scl_ver_cnt(a_scl), .v_phase(a_ph), .VSYNC(a_vs),
    .v_active(a_act), .frame_start(a_fs), .frame_cnt(a_fc)
  );

  param_vertical_timing_generator #(
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1), .SCALE(4),
    .CNT_W(4), .SCL_W(2), .SYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .reset(rst_b), .new_line(nl_b),
    .ver_cnt(b_ver), .scl_ver_cnt(b_scl), .v_phase(b_ph), .VSYNC(b_vs),
    .v_active(b_act), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  typedef struct {
    int steps;
    int line;
    int ph;
    int vs;
    int act;
    int scl;
    int fs;
  } vec_t;

  vec_t va[16];
  vec_t vb[9];
  int   checks   = 0;
  int   failures = 0;
  int   cur_a    = 0;

  function automatic vec_t mk(int s, int l, int p, int v, int a, int sc, int f);
    vec_t r;
    r.steps = s; r.line = l; r.ph = p; r.vs = v; r.act = a; r.scl = sc; r.fs = f;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input int l, input int p, input int v,
                         input int a, input int sc, input int f);
    chk($sformatf("%s ver_cnt", tag), int'(a_ver), l);
    chk($sformatf("%s v_phase", tag), int'(a_ph), p);
    chk($sformatf("%s VSYNC", tag), int'(a_vs), v);
    chk($sformatf("%s v_active", tag), int'(a_act), a);
    chk($sformatf("%s scl_ver_cnt", tag), int'(a_scl), sc);
    chk($sformatf("%s frame_start", tag), int'(a_fs), f);
  endtask

  // One new_line pulse every 4 clocks; returns one half-cycle after the edge
  // that sampled it, so single-cycle strobes are still visible.
  task automatic pulse_a();
    repeat (3) @(negedge clk);
    nl_a = 1'b1;
    @(negedge clk);
    nl_a = 1'b0;
    cur_a = (cur_a + 1) % 525;
  endtask

  initial begin
    int l, p, sc, frames, exp_fc;

    // line, phase, VSYNC, v_active, scl, frame_start for the default frame
    va[0]  = mk(0,   0,   0, 0, 0, 0,  0);
    va[1]  = mk(1,   1,   0, 0, 0, 0,  0);
    va[2]  = mk(1,   2,   1, 1, 0, 0,  0);
    va[3]  = mk(32,  34,  1, 1, 0, 0,  0);
    va[4]  = mk(1,   35,  2, 1, 1, 0,  0);
    va[5]  = mk(4,   39,  2, 1, 1, 0,  0);
    va[6]  = mk(1,   40,  2, 1, 1, 1,  0);
    va[7]  = mk(4,   44,  2, 1, 1, 1,  0);
    va[8]  = mk(1,   45,  2, 1, 1, 2,  0);
    va[9]  = mk(464, 509, 2, 1, 1, 94, 0);
    va[10] = mk(1,   510, 2, 1, 1, 95, 0);
    va[11] = mk(4,   514, 2, 1, 1, 95, 0);
    va[12] = mk(1,   515, 3, 1, 0, 0,  0);
    va[13] = mk(9,   524, 3, 1, 0, 0,  0);
    va[14] = mk(1,   0,   0, 0, 0, 0,  1);
    va[15] = mk(1,   1,   0, 0, 0, 0,  0);

    // small frame: one line per cycle, SYNC_POL=1, SCALE=4 with a short last row
    vb[0] = mk(1, 0, 0, 1, 0, 0, 1);
    vb[1] = mk(1, 1, 1, 0, 0, 0, 0);
    vb[2] = mk(1, 2, 2, 0, 1, 0, 0);
    vb[3] = mk(1, 3, 2, 0, 1, 0, 0);
    vb[4] = mk(1, 4, 2, 0, 1, 0, 0);
    vb[5] = mk(1, 5, 2, 0, 1, 0, 0);
    vb[6] = mk(1, 6, 2, 0, 1, 1, 0);
    vb[7] = mk(1, 7, 2, 0, 1, 1, 0);
    vb[8] = mk(1, 8, 3, 0, 0, 0, 0);

    // Reset held 3 cycles with new_line high: must stay at line 0.
    rst_a = 1'b1; rst_b = 1'b1; nl_a = 1'b1; nl_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset hold %0d ver_cnt", i), int'(a_ver), 0);
    end
    check_a("reset A", 0, 0, 0, 0, 0, 0);
    chk("reset A frame_cnt", int'(a_fc), 0);
    chk("reset A scale_cnt", int'(u_a.scale_cnt_r), 0);
    chk("reset B ver_cnt", int'(b_ver), 0);
    chk("reset B VSYNC", int'(b_vs), 1);
    chk("reset B v_active", int'(b_act), 0);
    chk("reset B frame_start", int'(b_fs), 0);
    rst_a = 1'b0; rst_b = 1'b0; nl_a = 1'b0; nl_b = 1'b0;
    @(negedge clk);
    chk("no frame_start on reset release", int'(a_fs), 0);

    // Table-driven walk through the key lines of the default frame.
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < va[i].steps; s++) pulse_a();
      check_a($sformatf("vec%0d", i), va[i].line, va[i].ph, va[i].vs,
              va[i].act, va[i].scl, va[i].fs);
    end

    // Second frame: every line checked against the line-order arithmetic.
    for (int i = 0; i < 524; i++) begin
      pulse_a();
      l  = cur_a;
      p  = (l < 2) ? 0 : (l < 35) ? 1 : (l < 515) ? 2 : 3;
      sc = (p == 2) ? (l - 35) / 5 : 0;
      check_a($sformatf("line%0d", l), l, p, (l < 2) ? 0 : 1,
              (p == 2) ? 1 : 0, sc, (l == 0) ? 1 : 0);
    end

    // Reset at line 300 coincident with new_line.
    for (int i = 0; i < 300; i++) pulse_a();
    chk("pre-reset ver_cnt", int'(a_ver), 300);
    rst_a = 1'b1; nl_a = 1'b1;
    @(negedge clk);
    check_a("mid reset", 0, 0, 0, 0, 0, 0);
    rst_a = 1'b0; nl_a = 1'b0;
    cur_a = 0;

    // Back-to-back new_line at line 33.
    for (int i = 0; i < 33; i++) pulse_a();
    chk("b2b start ver_cnt", int'(a_ver), 33);
    nl_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d ver_cnt", i), int'(a_ver), 34 + i);
      chk($sformatf("b2b%0d v_active", i), int'(a_act), (i == 0) ? 0 : 1);
      chk($sformatf("b2b%0d scl", i), int'(a_scl), 0);
      if (i > 0) chk($sformatf("b2b%0d scale_cnt", i), int'(u_a.scale_cnt_r), i - 1);
    end
    nl_a = 1'b0;
    @(negedge clk);
    chk("b2b hold ver_cnt", int'(a_ver), 36);

    // Small frame: new_line every cycle for 257 frames.
    nl_b = 1'b1;
    for (int k = 1; k <= 257 * 9; k++) begin
      @(negedge clk);
      l = k % 9;
      frames = k / 9;
      if (k <= 18) begin
        chk($sformatf("B k%0d ver_cnt", k), int'(b_ver), vb[l].line);
        chk($sformatf("B k%0d v_phase", k), int'(b_ph), vb[l].ph);
        chk($sformatf("B k%0d VSYNC", k), int'(b_vs), vb[l].vs);
        chk($sformatf("B k%0d v_active", k), int'(b_act), vb[l].act);
        chk($sformatf("B k%0d scl", k), int'(b_scl), vb[l].scl);
        chk($sformatf("B k%0d frame_start", k), int'(b_fs), vb[l].fs);
      end
      if (l == 0 && (frames == 1 || frames >= 255)) begin
`ifdef VTG_FRAME_CNT_EN
        exp_fc = frames % 256;
`else
        exp_fc = 0;
`endif
        chk($sformatf("B frame%0d frame_cnt", frames), int'(b_fc), exp_fc);
        chk($sformatf("B frame%0d frame_start", frames), int'(b_fs), 1);
      end
    end
    nl_b = 1'b0;
    @(negedge clk);
    chk("B final hold ver_cnt", int'(b_ver), 0);
    chk("B final frame_start low", int'(b_fs), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
